// File: rtl/tt_page_loader_if.sv
// Interface bundling the page loader's control, flash and teletext-buffer signals.
// master = the side that requests loads and models the flash; slave = the loader itself.
interface tt_page_loader_if;
  logic        load_req;
  logic [8:0]  load_page;
  logic        auto_en;
  logic [7:0]  flash_data;
  logic [20:0] flash_address;
  logic        tt_write;
  logic [9:0]  tt_address;
  logic [7:0]  tt_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  current_page;

  modport master (
    output load_req, load_page, auto_en, flash_data,
    input  flash_address, tt_write, tt_address, tt_data, busy, done, err, current_page
  );

  modport slave (
    input  load_req, load_page, auto_en, flash_data,
    output flash_address, tt_write, tt_address, tt_data, busy, done, err, current_page
  );
endinterface

// File: rtl/tt_page_loader.sv
// Teletext page loader: copies one page from parallel flash into the teletext
// buffer write port, either on request or by timed auto-advance.
// Every output is driven straight from a register.
module tt_page_loader #(
  parameter int PAGE_BYTES   = 1000,
  parameter int FLASH_WAIT   = 7,
  parameter int MAX_PAGE     = 485,
  parameter int DWELL_CYCLES = 2**28
) (
  input logic              clk,
  input logic              nrst,
  tt_page_loader_if.slave  bus
);

  localparam int WW = $clog2(FLASH_WAIT + 1);
  localparam int DW = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [8:0]    page_reg, page_next;
  logic [9:0]    byte_reg, byte_next;
  logic [WW-1:0] wait_reg, wait_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [20:0]   flash_address_reg, flash_address_next;
  logic          tt_write_reg, tt_write_next;
  logic [9:0]    tt_address_reg, tt_address_next;
  logic [7:0]    tt_data_reg, tt_data_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [8:0]    current_page_reg, current_page_next;

  logic          dwell_tick;
  logic          start;
  logic [8:0]    start_page;
  logic [8:0]    auto_page;

  // Auto-advance target wraps back to page 0 after the last valid page.
  assign auto_page  = (current_page_reg == 9'(MAX_PAGE)) ? 9'd0 : current_page_reg + 9'd1;
  assign dwell_tick = bus.auto_en && (dwell_reg == DW'(DWELL_CYCLES - 1));

  // Next-state and next-output logic; the dwell counter clears unless it is counting in IDLE.
  always_comb begin
    state_next         = state_reg;
    page_next          = page_reg;
    byte_next          = byte_reg;
    wait_next          = wait_reg;
    dwell_next         = '0;
    flash_address_next = flash_address_reg;
    tt_write_next      = 1'b0;
    tt_address_next    = tt_address_reg;
    tt_data_next       = tt_data_reg;
    busy_next          = busy_reg;
    done_next          = 1'b0;
    err_next           = 1'b0;
    current_page_next  = current_page_reg;
    start              = 1'b0;
    start_page         = auto_page;

    case (state_reg)
      IDLE: begin
        if (bus.auto_en && !dwell_tick) begin
          dwell_next = dwell_reg + DW'(1);
        end
        // A manual request takes priority; an auto tick in the same cycle is dropped.
        if (bus.load_req) begin
          if (bus.load_page <= 9'(MAX_PAGE)) begin
            start      = 1'b1;
            start_page = bus.load_page;
          end else begin
            err_next = 1'b1;
          end
        end else if (dwell_tick) begin
          start = 1'b1;
        end
        if (start) begin
          state_next         = FETCH;
          page_next          = start_page;
          byte_next          = 10'd0;
          wait_next          = WW'(FLASH_WAIT);
          flash_address_next = {2'b00, start_page, 10'd0};
          busy_next          = 1'b1;
          dwell_next         = '0;
        end
      end

      FETCH: begin
        if (wait_reg == '0) begin
          tt_write_next   = 1'b1;
          tt_address_next = byte_reg;
          tt_data_next    = bus.flash_data;
          if (byte_reg == 10'(PAGE_BYTES - 1)) begin
            // Leave the flash address on the last byte so it holds through IDLE.
            state_next = DONE;
          end else begin
            byte_next          = byte_reg + 10'd1;
            wait_next          = WW'(FLASH_WAIT);
            flash_address_next = {2'b00, page_reg, byte_reg + 10'd1};
          end
        end else begin
          wait_next = wait_reg - WW'(1);
        end
      end

      DONE: begin
        done_next         = 1'b1;
        busy_next         = 1'b0;
        current_page_next = page_reg;
        state_next        = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any load immediately.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg         <= IDLE;
      page_reg          <= 9'd0;
      byte_reg          <= 10'd0;
      wait_reg          <= '0;
      dwell_reg         <= '0;
      flash_address_reg <= 21'd0;
      tt_write_reg      <= 1'b0;
      tt_address_reg    <= 10'd0;
      tt_data_reg       <= 8'd0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      err_reg           <= 1'b0;
      current_page_reg  <= 9'd0;
    end else begin
      state_reg         <= state_next;
      page_reg          <= page_next;
      byte_reg          <= byte_next;
      wait_reg          <= wait_next;
      dwell_reg         <= dwell_next;
      flash_address_reg <= flash_address_next;
      tt_write_reg      <= tt_write_next;
      tt_address_reg    <= tt_address_next;
      tt_data_reg       <= tt_data_next;
      busy_reg          <= busy_next;
      done_reg          <= done_next;
      err_reg           <= err_next;
      current_page_reg  <= current_page_next;
    end
  end

  assign bus.flash_address = flash_address_reg;
  assign bus.tt_write      = tt_write_reg;
  assign bus.tt_address    = tt_address_reg;
  assign bus.tt_data       = tt_data_reg;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.err           = err_reg;
  assign bus.current_page  = current_page_reg;

endmodule

// File: tb/tb_tt_page_loader.sv
// Directed testbench for tt_page_loader with a small geometry
// (4-byte pages, 2 wait cycles, pages 0..5, 20-cycle dwell).
module tb_tt_page_loader;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_err;

  tt_page_loader_if bus();

  // Flash model: data is the low address byte XOR 0xA5.
  assign bus.flash_data = bus.flash_address[7:0] ^ 8'hA5;

  tt_page_loader #(
    .PAGE_BYTES  (4),
    .FLASH_WAIT  (2),
    .MAX_PAGE    (5),
    .DWELL_CYCLES(20)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations gathered by observe(); cycle 1 is the cycle after the start edge.
  int          obs_n_wr;
  int          obs_done_cyc;
  int          obs_busy_n;
  int          obs_busy_first;
  int          obs_err_n;
  int          obs_wr_cyc   [8];
  logic [9:0]  obs_wr_addr  [8];
  logic [7:0]  obs_wr_data  [8];
  logic [8:0]  obs_wr_fpage [8];
  logic [20:0] obs_faddr1;
  logic [2:0]  obs_snap;
  logic [8:0]  obs_snap_page;
  logic [20:0] obs_snap_faddr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples ncyc cycles, optionally pulsing load_req or reset at given cycles.
  task automatic observe(input int ncyc, input int pulse_cyc, input logic [8:0] pulse_page,
                         input int rst_cyc);
    obs_n_wr       = 0;
    obs_done_cyc   = 0;
    obs_busy_n     = 0;
    obs_busy_first = 0;
    obs_err_n      = 0;
    obs_faddr1     = '1;
    obs_snap       = '1;
    obs_snap_page  = '1;
    obs_snap_faddr = '1;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == 1) begin
        obs_faddr1     = bus.flash_address;
        obs_busy_first = int'(bus.busy);
      end
      if (bus.tt_write) begin
        $display("  cycle %0d: write addr=%0d data=0x%02h flash_page=%0d", c, bus.tt_address,
                 bus.tt_data, bus.flash_address[18:10]);
        if (obs_n_wr < 8) begin
          obs_wr_cyc[obs_n_wr]   = c;
          obs_wr_addr[obs_n_wr]  = bus.tt_address;
          obs_wr_data[obs_n_wr]  = bus.tt_data;
          obs_wr_fpage[obs_n_wr] = bus.flash_address[18:10];
        end
        obs_n_wr++;
      end
      if (bus.busy) obs_busy_n++;
      if (bus.err) obs_err_n++;
      if (bus.done && obs_done_cyc == 0) obs_done_cyc = c;
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        obs_snap       = {bus.tt_write, bus.busy, bus.done};
        obs_snap_page  = bus.current_page;
        obs_snap_faddr = bus.flash_address;
      end
      bus.load_req = (c == pulse_cyc);
      if (c == pulse_cyc) bus.load_page = pulse_page;
      if (c == rst_cyc) nrst = 1'b0;
      if (c == rst_cyc + 2) nrst = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({bus.tt_write, bus.tt_address, bus.tt_data, bus.flash_address, bus.busy, bus.done,
         bus.err, bus.current_page} !== 53'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got wr=%0b ta=%0d td=%02h fa=%06h busy=%0b done=%0b err=%0b page=%0d want all 0",
               bus.tt_write, bus.tt_address, bus.tt_data, bus.flash_address, bus.busy, bus.done,
               bus.err, bus.current_page);
    end
    nrst = 1'b1;
    step();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy: got %0b want 0", bus.busy);
    end
    $display("reset: checked");
  endtask

  task automatic test_load_page3();
    logic [7:0] exp_d;
    bus.load_page = 9'd3;
    bus.load_req  = 1'b1;
    step();
    observe(16, 0, 9'd0, 0);
    n_cmp++;
    if (obs_n_wr !== 4) begin
      n_err++;
      $display("FAIL load3_count: got %0d writes want 4", obs_n_wr);
    end
    for (int k = 0; k < 4; k++) begin
      exp_d = 8'(k) ^ 8'hA5;
      n_cmp++;
      if (obs_wr_cyc[k] !== 4 + 3 * k) begin
        n_err++;
        $display("FAIL load3_cycle[%0d]: got %0d want %0d", k, obs_wr_cyc[k], 4 + 3 * k);
      end
      n_cmp++;
      if (obs_wr_addr[k] !== 10'(k)) begin
        n_err++;
        $display("FAIL load3_addr[%0d]: got %0d want %0d", k, obs_wr_addr[k], k);
      end
      n_cmp++;
      if (obs_wr_data[k] !== exp_d) begin
        n_err++;
        $display("FAIL load3_data[%0d]: got %02h want %02h", k, obs_wr_data[k], exp_d);
      end
    end
    n_cmp++;
    if (obs_faddr1 !== 21'h000C00) begin
      n_err++;
      $display("FAIL load3_flash_addr: got %06h want 000c00", obs_faddr1);
    end
    n_cmp++;
    if (obs_done_cyc !== 14) begin
      n_err++;
      $display("FAIL load3_done_cycle: got %0d want 14", obs_done_cyc);
    end
    n_cmp++;
    if (obs_busy_n !== 13 || obs_busy_first !== 1) begin
      n_err++;
      $display("FAIL load3_busy: got %0d cycles (first=%0d) want 13 (first=1)", obs_busy_n,
               obs_busy_first);
    end
    n_cmp++;
    if (bus.current_page !== 9'd3) begin
      n_err++;
      $display("FAIL load3_page: got %0d want 3", bus.current_page);
    end
    $display("load page 3: %0d writes, done at cycle %0d", obs_n_wr, obs_done_cyc);
  endtask

  task automatic test_reject();
    bus.load_page = 9'd6;
    bus.load_req  = 1'b1;
    step();
    bus.load_req = 1'b0;
    n_cmp++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reject_err: got err=%0b busy=%0b want err=1 busy=0", bus.err, bus.busy);
    end
    observe(6, 0, 9'd0, 0);
    n_cmp++;
    if (obs_err_n !== 1 || obs_n_wr !== 0 || obs_busy_n !== 0) begin
      n_err++;
      $display("FAIL reject_quiet: got err_cycles=%0d writes=%0d busy_cycles=%0d want 1/0/0",
               obs_err_n, obs_n_wr, obs_busy_n);
    end
    n_cmp++;
    if (bus.current_page !== 9'd3) begin
      n_err++;
      $display("FAIL reject_page: got %0d want 3", bus.current_page);
    end
    $display("reject page 6: err cycles=%0d", obs_err_n);
  endtask

  task automatic test_auto_wrap();
    bus.load_page = 9'd5;
    bus.load_req  = 1'b1;
    step();
    observe(13, 0, 9'd0, 0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.current_page !== 9'd5) begin
      n_err++;
      $display("FAIL auto_setup: got done=%0b page=%0d want done=1 page=5", bus.done,
               bus.current_page);
    end
    bus.auto_en = 1'b1;
    observe(19, 0, 9'd0, 0);
    n_cmp++;
    if (obs_busy_n !== 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL auto_early: got busy_cycles=%0d busy=%0b want 0/0", obs_busy_n, bus.busy);
    end
    step();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.flash_address !== 21'h000000) begin
      n_err++;
      $display("FAIL auto_start: got busy=%0b fa=%06h want busy=1 fa=000000", bus.busy,
               bus.flash_address);
    end
    observe(13, 0, 9'd0, 0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.current_page !== 9'd0 || obs_n_wr !== 4) begin
      n_err++;
      $display("FAIL auto_done: got done=%0b page=%0d writes=%0d want 1/0/4", bus.done,
               bus.current_page, obs_n_wr);
    end
    bus.auto_en = 1'b0;
    $display("auto advance 5 -> %0d", bus.current_page);
  endtask

  task automatic test_busy_ignore();
    int bad;
    bus.load_page = 9'd2;
    bus.load_req  = 1'b1;
    step();
    observe(13, 5, 9'd1, 0);
    bad = 0;
    for (int k = 0; k < 4; k++) if (obs_wr_fpage[k] !== 9'd2) bad++;
    n_cmp++;
    if (obs_n_wr !== 4 || bad !== 0) begin
      n_err++;
      $display("FAIL ignore_writes: got %0d writes, %0d off-page want 4, 0", obs_n_wr, bad);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.current_page !== 9'd2) begin
      n_err++;
      $display("FAIL ignore_page: got done=%0b page=%0d want done=1 page=2", bus.done,
               bus.current_page);
    end
    bus.auto_en = 1'b1;
    observe(19, 0, 9'd0, 0);
    n_cmp++;
    if (obs_busy_n !== 0) begin
      n_err++;
      $display("FAIL ignore_not_queued: got %0d busy cycles want 0", obs_busy_n);
    end
    bus.load_page = 9'd4;
    bus.load_req  = 1'b1;
    step();
    bus.load_req = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.flash_address !== 21'h001000) begin
      n_err++;
      $display("FAIL priority_start: got busy=%0b fa=%06h want busy=1 fa=001000", bus.busy,
               bus.flash_address);
    end
    observe(13, 0, 9'd0, 0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.current_page !== 9'd4) begin
      n_err++;
      $display("FAIL priority_page: got done=%0b page=%0d want done=1 page=4", bus.done,
               bus.current_page);
    end
    bus.auto_en = 1'b0;
    $display("busy ignore / manual priority: page %0d", bus.current_page);
  endtask

  task automatic test_reset_mid_load();
    bus.load_page = 9'd1;
    bus.load_req  = 1'b1;
    step();
    observe(16, 0, 9'd0, 8);
    n_cmp++;
    if (obs_n_wr !== 2 || obs_busy_n !== 8 || obs_done_cyc !== 0) begin
      n_err++;
      $display("FAIL rstmid_abort: got writes=%0d busy_cycles=%0d done_cycle=%0d want 2/8/0",
               obs_n_wr, obs_busy_n, obs_done_cyc);
    end
    n_cmp++;
    if (obs_snap !== 3'b000 || obs_snap_page !== 9'd0 || obs_snap_faddr !== 21'd0) begin
      n_err++;
      $display("FAIL rstmid_state: got wr/busy/done=%03b page=%0d fa=%06h want 000/0/000000",
               obs_snap, obs_snap_page, obs_snap_faddr);
    end
    bus.load_page = 9'd2;
    bus.load_req  = 1'b1;
    step();
    observe(13, 0, 9'd0, 0);
    n_cmp++;
    if (obs_n_wr !== 4 || obs_wr_cyc[0] !== 4 || obs_wr_addr[0] !== 10'd0) begin
      n_err++;
      $display("FAIL rstmid_reload: got writes=%0d first_cycle=%0d first_addr=%0d want 4/4/0",
               obs_n_wr, obs_wr_cyc[0], obs_wr_addr[0]);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.current_page !== 9'd2) begin
      n_err++;
      $display("FAIL rstmid_page: got done=%0b page=%0d want done=1 page=2", bus.done,
               bus.current_page);
    end
    $display("reset mid-load: reload page %0d", bus.current_page);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    nrst          = 1'b0;
    bus.load_req  = 1'b0;
    bus.load_page = 9'd0;
    bus.auto_en   = 1'b0;
    test_reset();
    test_load_page3();
    test_reject();
    test_auto_wrap();
    test_busy_ignore();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
